// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture monitor:
// segment patterns, anode codes, FSM states and BCD conversion.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_THOU = 4'b0111;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_UNIT = 4'b1110;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Digits are 0..9 by construction, so 9999 fits comfortably.
  function automatic logic [15:0] bcd_to_bin(input logic [15:0] bcd);
    logic [13:0] p3;
    p3 = 14'(bcd[15:12]) * 14'd1000;
    return {2'b00, p3}
         + 16'(bcd[11:8]) * 16'd100
         + 16'(bcd[7:4]) * 16'd10
         + 16'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Active-low seven-segment pattern to decimal digit decoder.
// Any pattern outside the ten digit glyphs is reported illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] digit
);

  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    unique case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Reconstructs the 4-digit number shown on a scanned seven-segment
// display, emitting one BCD/binary frame per completed scan.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [6:0]  ledSEG,
  output logic [15:0] digits,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        timeout
);

  localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  logic [3:0]       an1_q, an1_d, an2_q, an2_d;
  logic [6:0]       seg1_q, seg1_d, seg2_q, seg2_d;
  logic [15:0]      stab_q, stab_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  state_e           state_q, state_d;
  logic [15:0]      result_q, result_d;
  logic [31:0]      to_q, to_d;
  logic [15:0]      digits_q, digits_d;
  logic [15:0]      value_q, value_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic             tout_q, tout_d;

  logic             an_legal;
  logic [1:0]       pos;
  logic             stable;
  logic             cap;
  logic             dec_legal;
  logic [3:0]       dec_digit;
  logic [3:0]       cap_mask;

  seg7_pattern_decode u_dec (
    .seg   (seg1_q),
    .legal (dec_legal),
    .digit (dec_digit)
  );

  always_comb begin
    an_legal = 1'b1;
    pos      = 2'd0;
    unique case (an1_q)
      AN_THOU: pos = 2'd3;
      AN_HUND: pos = 2'd2;
      AN_TENS: pos = 2'd1;
      AN_UNIT: pos = 2'd0;
      default: an_legal = 1'b0;
    endcase
  end

  // Capture on the one increment that lands on STABLE_CYCLES.
  always_comb begin
    an1_d  = AN;
    seg1_d = ledSEG;
    an2_d  = an1_q;
    seg2_d = seg1_q;
    stable = an_legal && (an1_q == an2_q) && (seg1_q == seg2_q);
    cap    = stable && (stab_q == STAB_LAST);
    if (!stable) begin
      stab_d = 16'd0;
    end else if (&stab_q) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 16'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    result_d = result_q;
    to_d     = to_q;
    digits_d = digits_q;
    value_d  = value_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    tout_d   = 1'b0;
    cap_mask = mask_q | (4'(1) << pos);
    unique case (state_q)
      COLLECT: begin
        if (cap && dec_legal && (cap_mask == 4'hF)) begin
          // A completing capture beats a coincident timeout.
          shadow_d[pos] = dec_digit;
          mask_d        = cap_mask;
          state_d       = CONVERT;
        end else begin
          if (cap && dec_legal) begin
            shadow_d[pos] = dec_digit;
            mask_d        = cap_mask;
          end else if (cap) begin
            mask_d = 4'd0;
            err_d  = 1'b1;
          end
          if (to_q == TO_LAST) begin
            to_d   = 32'd0;
            tout_d = 1'b1;
            mask_d = 4'd0;
          end else begin
            to_d = to_q + 32'd1;
          end
        end
      end
      CONVERT: begin
        result_d = bcd_to_bin(shadow_q);
        mask_d   = 4'd0;
        state_d  = EMIT;
      end
      EMIT: begin
        digits_d = shadow_q;
        value_d  = result_q;
        fv_d     = 1'b1;
        to_d     = 32'd0;
        state_d  = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an1_q    <= 4'd0;
      an2_q    <= 4'd0;
      seg1_q   <= 7'd0;
      seg2_q   <= 7'd0;
      stab_q   <= 16'd0;
      mask_q   <= 4'd0;
      shadow_q <= '0;
      state_q  <= COLLECT;
      result_q <= 16'd0;
      to_q     <= 32'd0;
      digits_q <= 16'd0;
      value_q  <= 16'd0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      an1_q    <= an1_d;
      an2_q    <= an2_d;
      seg1_q   <= seg1_d;
      seg2_q   <= seg2_d;
      stab_q   <= stab_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      state_q  <= state_d;
      result_q <= result_d;
      to_q     <= to_d;
      digits_q <= digits_d;
      value_q  <= value_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  assign digits      = digits_q;
  assign value       = value_q;
  assign frame_valid = fv_q;
  assign seg_err     = err_q;
  assign timeout     = tout_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed frame table,
// corner-case sequences and randomized scans against a run-length model.
module tb_seg7_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 200;

  logic        clk;
  logic        rst;
  logic [3:0]  AN;
  logic [6:0]  ledSEG;
  logic [15:0] digits;
  logic [15:0] value;
  logic        frame_valid;
  logic        seg_err;
  logic        timeout;

  seg7_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .AN          (AN),
    .ledSEG      (ledSEG),
    .digits      (digits),
    .value       (value),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                           7'b0000110, 7'b1001100, 7'b0100100,
                           7'b0100000, 7'b0001111, 7'b0000000,
                           7'b0000100};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_fv = 0;
  int n_err = 0;
  int n_to = 0;
  int to_cyc = -1;

  // Reference model state
  logic [10:0] m_prev;
  int          m_run;
  int          m_mask;
  logic [3:0]  m_sh [4];
  int          m_busy;
  int          m_tc;
  logic [15:0] e_digits;
  logic [15:0] e_value;
  logic        e_fv, e_err, e_to;

  function automatic int seg_dig(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == PAT[i]) return i;
    return -1;
  endfunction

  function automatic int an_pos(input logic [3:0] a);
    case (a)
      4'b0111: return 3;
      4'b1011: return 2;
      4'b1101: return 1;
      4'b1110: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] an_code(input int p);
    case (p)
      3:       return 4'b0111;
      2:       return 4'b1011;
      1:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic model_reset();
    m_prev   = 11'h0;
    m_run    = 0;
    m_mask   = 0;
    for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
    m_busy   = 0;
    m_tc     = 0;
    e_digits = 16'd0;
    e_value  = 16'd0;
    e_fv     = 1'b0;
    e_err    = 1'b0;
    e_to     = 1'b0;
  endtask

  // A held input is captured on the edge after it has been sampled
  // STABLE+1 times in a row (one input register, then STABLE matches).
  task automatic model_edge(input logic [10:0] x);
    bit cap;
    int p, d;
    e_fv  = 1'b0;
    e_err = 1'b0;
    e_to  = 1'b0;
    p     = an_pos(m_prev[10:7]);
    d     = seg_dig(m_prev[6:0]);
    cap   = (m_run == STABLE + 1) && (p >= 0);
    if (m_busy == 2) begin
      m_busy = 1;
      m_mask = 0;
    end else if (m_busy == 1) begin
      m_busy   = 0;
      e_digits = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      e_value  = 16'(int'(m_sh[3]) * 1000 + int'(m_sh[2]) * 100
                   + int'(m_sh[1]) * 10 + int'(m_sh[0]));
      e_fv     = 1'b1;
      m_tc     = 0;
    end else if (cap && d >= 0 && ((m_mask | (1 << p)) == 15)) begin
      m_sh[p] = 4'(d);
      m_mask  = 15;
      m_busy  = 2;
    end else begin
      if (cap && d >= 0) begin
        m_sh[p] = 4'(d);
        m_mask  = m_mask | (1 << p);
      end else if (cap) begin
        m_mask = 0;
        e_err  = 1'b1;
      end
      m_tc++;
      if (m_tc == TIMEOUT) begin
        m_tc   = 0;
        e_to   = 1'b1;
        m_mask = 0;
      end
    end
    if (x == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = x;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] sg);
    AN     = an;
    ledSEG = sg;
    @(posedge clk);
    model_edge({an, sg});
    cyc++;
    #1;
    checks++;
    if ({frame_valid, seg_err, timeout} !== {e_fv, e_err, e_to}) begin
      failures++;
      $display("FAIL pulses cyc=%0d got fv/err/to=%b%b%b expected=%b%b%b",
               cyc, frame_valid, seg_err, timeout, e_fv, e_err, e_to);
    end
    checks++;
    if (digits !== e_digits || value !== e_value) begin
      failures++;
      $display("FAIL data cyc=%0d got digits=%h value=%0d expected digits=%h value=%0d",
               cyc, digits, value, e_digits, e_value);
    end
    if (frame_valid) n_fv++;
    if (seg_err) n_err++;
    if (timeout) begin
      n_to++;
      to_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    AN     = 4'hF;
    ledSEG = 7'h7F;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits", int'(digits), 0);
    chk("reset_value", int'(value), 0);
    chk("reset_pulses", int'({frame_valid, seg_err, timeout}), 0);
    model_reset();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic clr_counts();
    n_fv   = 0;
    n_err  = 0;
    n_to   = 0;
    to_cyc = -1;
  endtask

  task automatic scan_digit(input int p, input logic [6:0] sg, input int dw);
    repeat (dw) step(an_code(p), sg);
  endtask

  task automatic scan(input logic [15:0] bcd, input int dw);
    for (int p = 3; p >= 0; p--) scan_digit(p, PAT[bcd[p*4 +: 4]], dw);
  endtask

  typedef struct {
    logic [15:0] bcd;
    int          val;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [3:0] an;
    logic [6:0] sg;
    int         dw;
    int         pi;

    tbl[0] = '{16'h1234, 1234};
    tbl[1] = '{16'h9999, 9999};
    tbl[2] = '{16'h0007, 7};
    tbl[3] = '{16'h0000, 0};
    tbl[4] = '{16'h8056, 8056};

    rst    = 1'b1;
    AN     = 4'hF;
    ledSEG = 7'h7F;
    do_reset();

    // Continuous scanning of the frame table.
    for (int i = 0; i < 5; i++) begin
      clr_counts();
      scan(tbl[i].bcd, 10);
      chk("tbl_frames", n_fv, 1);
      chk("tbl_digits", int'(digits), int'(tbl[i].bcd));
      chk("tbl_value", int'(value), tbl[i].val);
      chk("tbl_seg_err", n_err, 0);
    end

    // Illegal units pattern, then a lone units digit must not complete.
    clr_counts();
    scan_digit(3, PAT[5], 10);
    scan_digit(2, PAT[6], 10);
    scan_digit(1, PAT[7], 10);
    scan_digit(0, 7'h7F, 10);
    chk("err_pulse", n_err, 1);
    chk("err_no_frame", n_fv, 0);
    scan_digit(0, PAT[8], 10);
    chk("err_mask_cleared", n_fv, 0);
    scan(16'h5678, 10);
    chk("err_recover_frames", n_fv, 1);
    chk("err_recover_value", int'(value), 5678);

    // Short dwells with blank gaps never capture.
    clr_counts();
    for (int r = 0; r < 3; r++) begin
      for (int p = 3; p >= 0; p--) begin
        scan_digit(p, (p == 1) ? 7'h55 : PAT[p + r], 3);
        repeat (2) step(4'hF, PAT[p]);
      end
    end
    chk("short_no_frame", n_fv, 0);
    chk("short_no_err", n_err, 0);
    chk("short_hold_value", int'(value), 5678);

    // Reset after three captured digits discards them.
    scan_digit(3, PAT[9], 10);
    scan_digit(2, PAT[9], 10);
    scan_digit(1, PAT[9], 10);
    do_reset();
    clr_counts();
    scan_digit(0, PAT[1], 10);
    chk("rst_no_stale_frame", n_fv, 0);
    scan(16'h4321, 10);
    chk("rst_frames", n_fv, 1);
    chk("rst_digits", int'(digits), 16'h4321);
    chk("rst_value", int'(value), 4321);

    // Partial scan times out at cycle 200 after reset.
    do_reset();
    clr_counts();
    for (int r = 0; r < 25; r++) scan_digit((r % 2 == 0) ? 3 : 2, PAT[r % 10], 10);
    chk("to_count", n_to, 1);
    chk("to_cycle", to_cyc, 200);
    chk("to_value", int'(value), 0);
    chk("to_digits", int'(digits), 0);
    chk("to_no_frame", n_fv, 0);

    // Randomized scans against the model.
    do_reset();
    pi = 3;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        an = 4'hF;
      end else begin
        an = an_code(pi);
        pi = (pi == 0) ? 3 : pi - 1;
      end
      if ($urandom_range(0, 9) == 0) sg = 7'($urandom);
      else sg = PAT[$urandom_range(0, 9)];
      if ($urandom_range(0, 2) == 0) dw = $urandom_range(1, 3);
      else dw = $urandom_range(6, 14);
      repeat (dw) step(an, sg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the team's multiplexed 4-digit seven-segment driver.
- Watches the scanned anode-select and active-low segment lines and reconstructs the 4-digit decimal number being displayed.
- Reports that number as BCD digits plus a binary value, one frame at a time.
- Used as a loopback/self-check monitor beside the display driver and as a bench reference model.

Parameters:
- STABLE_CYCLES, 16: consecutive unchanged cycles required before a digit is captured (range 2..65535).
- TIMEOUT_CYCLES, 4000000: cycles without a completed frame before the partial frame is discarded. Must exceed 4 × scan dwell.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- AN  input  4  anode select, active-low one-hot. 0111 = thousands, 1011 = hundreds, 1101 = tens, 1110 = units.
- ledSEG  input  7  segments a..g, bit6 = a, active-low.
- digits  output  16  captured BCD: [15:12] thousands … [3:0] units.
- value  output  16  binary value d3*1000 + d2*100 + d1*10 + d0, range 0..9999.
- frame_valid  output  1  one-cycle pulse; digits/value updated in the same cycle.
- seg_err  output  1  one-cycle pulse: illegal segment pattern captured.
- timeout  output  1  one-cycle pulse: partial frame discarded.

Behaviour:
- Reset: all outputs 0, mask 0000, counters 0, state COLLECT. Reset mid-frame discards all partial data. No output pulse on release.
- Input stage: AN and ledSEG registered once (s1); previous copy held in s2.
- Stability counter (16 bit, saturating):
  - Cleared when s1 != s2 on either bus, or when s1 AN is not a legal one-hot-low code.
  - Otherwise increments.
- Capture: fires on the single cycle the counter reaches STABLE_CYCLES. Exactly one capture per dwell, with no re-capture until the counter clears.
- Illegal AN codes (1111 blank, multi-hot) never capture and are not errors.
- Segment decode, active-low:
  - 0000001 → 0, 1001111 → 1, 0010010 → 2, 0000110 → 3, 1001100 → 4
  - 0100100 → 5, 0100000 → 6, 0001111 → 7, 0000000 → 8, 0000100 → 9
  - Any other pattern is illegal.
- Legal capture: digit written to the shadow register for that position; mask bit set. A recaptured position overwrites its shadow; the mask bit stays set.
- Illegal capture: seg_err pulses the cycle after the capture edge, mask cleared to 0000, shadow unchanged.
- FSM:
  - COLLECT → CONVERT on the edge at which the mask becomes 1111.
  - CONVERT: value computed from the shadow and registered; mask cleared; captures during CONVERT are ignored.
  - EMIT: digits ← shadow, value ← result, frame_valid = 1 for one cycle, timeout counter cleared. Then → COLLECT.
  - Latency: frame_valid is asserted 2 cycles after the capture edge that completes the mask.
- Arithmetic: d3*1000 uses a 14-bit product; the sum is zero-extended to 16 bits. Shadow digits are always 0..9 by construction.
- Timeout counter (32 bit):
  - Counts in COLLECT; cleared on EMIT and on reset.
  - At TIMEOUT_CYCLES: timeout pulses, mask cleared, counter restarts from 0.
  - If a mask-completing capture occurs on the same cycle as timeout, the capture wins: no timeout, go to CONVERT.
- Simultaneous illegal capture and timeout: both pulses assert; mask cleared.
- digits/value hold their last frame between frames, including across errors and timeouts.

Decomposition:
- Package seg7_pkg contains:
  - the ten segment pattern constants and the blank pattern;
  - the four anode codes;
  - the FSM state enum {COLLECT, CONVERT, EMIT}.
- Sub-module seg7_pattern_decode: combinational 7-bit pattern → {legal, 4-bit digit}. Shared with the driver-side checker.
- Stability counter, mask, FSM and arithmetic stay in the top module.

Test Plan:
- Bench uses STABLE_CYCLES = 4, TIMEOUT_CYCLES = 200.
- Scan 1,2,3,4 with each AN code held 10 cycles and the matching patterns → one frame_valid; digits = 16'h1234; value = 1234; no seg_err.
- Scan 9,9,9,9 then 0,0,0,7 continuously → frame_valid with value 9999, then value 7. Exactly one capture per dwell, no pulses in between.
- Units dwell carries 1111111 → seg_err one cycle; mask cleared; the next clean full scan of 5,6,7,8 yields value 5678.
- Scan only thousands and hundreds for 250 cycles → timeout pulse at cycle 200 after reset; digits/value still 0.
- Dwell of 3 cycles (< STABLE_CYCLES) on each digit, plus AN = 1111 gaps → no capture, no frame_valid, no seg_err.
- Assert rst after 3 of 4 digits captured → outputs 0. A subsequent full scan of 4,3,2,1 yields value 4321, and no stale digits are used.
